// File: rtl/snake_pixel_renderer.sv
// Snake game VGA pixel stage: maps pixels to grid cells, reads grid RAM, drives RGB.
// Optional macro SNAKE_GRID_LINES_EN draws 20_20_20 grid lines on empty cells.
module snake_pixel_renderer #(
    parameter int CELL_SHIFT = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_blank,
    input  logic [11:0] CounterX,
    input  logic [11:0] CounterY,
    input  logic        game_over,
    output logic        grid_rd,
    output logic [10:0] grid_addr,
    input  logic [1:0]  grid_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic [5:0]  frame_cnt
);

    localparam logic [11:0] GW = 12'(GRID_W);
    localparam logic [11:0] GH = 12'(GRID_H);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BODY  = 2'b01;
    localparam logic [1:0] CELL_HEAD  = 2'b10;
    localparam logic [1:0] CELL_FOOD  = 2'b11;

    logic [11:0] col;
    logic [11:0] row;
    logic        in_grid;
    logic [10:0] addr;

    assign col     = CounterX >> CELL_SHIFT;
    assign row     = CounterY >> CELL_SHIFT;
    assign in_grid = in_blank & (col < GW) & (row < GH);
    assign addr    = in_grid ? 11'(row) * 11'(GRID_W) + 11'(col) : 11'd0;

    logic s0_in_grid, s0_hs, s0_vs, s0_blank;
    logic s1_in_grid, s1_hs, s1_vs, s1_blank;
    logic vs_q;
    logic [23:0] rgb;

`ifdef SNAKE_GRID_LINES_EN
    logic cell_edge;
    logic s0_edge, s1_edge;

    assign cell_edge = (CounterX[CELL_SHIFT-1:0] == '0) |
                       (CounterY[CELL_SHIFT-1:0] == '0);

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_edge <= 1'b0;
            s1_edge <= 1'b0;
        end else begin
            s0_edge <= cell_edge;
            s1_edge <= s0_edge;
        end
    end
`endif

    // Stages 0 and 1: address issue, then side info waits for RAM data
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            grid_rd    <= 1'b0;
            grid_addr  <= 11'd0;
            s0_in_grid <= 1'b0;
            s0_hs      <= 1'b1;
            s0_vs      <= 1'b1;
            s0_blank   <= 1'b0;
            s1_in_grid <= 1'b0;
            s1_hs      <= 1'b1;
            s1_vs      <= 1'b1;
            s1_blank   <= 1'b0;
        end else begin
            grid_rd    <= in_grid;
            grid_addr  <= addr;
            s0_in_grid <= in_grid;
            s0_hs      <= in_hs;
            s0_vs      <= in_vs;
            s0_blank   <= in_blank;
            s1_in_grid <= s0_in_grid;
            s1_hs      <= s0_hs;
            s1_vs      <= s0_vs;
            s1_blank   <= s0_blank;
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q      <= 1'b1;
            frame_cnt <= 6'd0;
        end else begin
            vs_q <= in_vs;
            if (vs_q & ~in_vs)
                frame_cnt <= frame_cnt + 6'd1;
        end
    end

    // Stage 2: colour select by priority
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb       <= 24'h000000;
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_blank <= 1'b0;
        end else begin
            vga_hs    <= s1_hs;
            vga_vs    <= s1_vs;
            vga_blank <= s1_blank;
            if (!s1_blank)
                rgb <= 24'h000000;
            else if (!s1_in_grid)
                rgb <= 24'h404040;
            else if (game_over & frame_cnt[4] &
                     (grid_data == CELL_BODY || grid_data == CELL_HEAD))
                rgb <= 24'hFF0000;
            else begin
                case (grid_data)
                    CELL_HEAD: rgb <= 24'hFFFF00;
                    CELL_BODY: rgb <= 24'h00C000;
                    CELL_FOOD: rgb <= frame_cnt[4] ? 24'hFF0000 : 24'h000000;
`ifdef SNAKE_GRID_LINES_EN
                    CELL_EMPTY: rgb <= s1_edge ? 24'h202020 : 24'h000000;
`else
                    CELL_EMPTY: rgb <= 24'h000000;
`endif
                    default:   rgb <= 24'h000000;
                endcase
            end
        end
    end

    assign vga_r = rgb[23:16];
    assign vga_g = rgb[15:8];
    assign vga_b = rgb[7:0];

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Directed bench for snake_pixel_renderer with a behavioural grid RAM.
module tb_snake_pixel_renderer;

    logic        pixel_clk;
    logic        reset_n;
    logic        in_hs;
    logic        in_vs;
    logic        in_blank;
    logic [11:0] CounterX;
    logic [11:0] CounterY;
    logic        game_over;
    logic        grid_rd;
    logic [10:0] grid_addr;
    logic [1:0]  grid_data;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank;
    logic [5:0]  frame_cnt;

    logic [1:0] mem [0:2047];
    int errors = 0;
    int checks = 0;
    logic [23:0] exp_line;

    snake_pixel_renderer dut (
        .pixel_clk (pixel_clk),
        .reset_n   (reset_n),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_blank  (in_blank),
        .CounterX  (CounterX),
        .CounterY  (CounterY),
        .game_over (game_over),
        .grid_rd   (grid_rd),
        .grid_addr (grid_addr),
        .grid_data (grid_data),
        .vga_r     (vga_r),
        .vga_g     (vga_g),
        .vga_b     (vga_b),
        .vga_hs    (vga_hs),
        .vga_vs    (vga_vs),
        .vga_blank (vga_blank),
        .frame_cnt (frame_cnt)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    initial grid_data = 2'b00;
    always @(posedge pixel_clk)
        if (grid_rd) grid_data <= mem[grid_addr];

    task automatic tick(input int n);
        repeat (n) @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic vs_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            in_vs = 1'b0;
            tick(1);
            in_vs = 1'b1;
            tick(1);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_hs"},    32'(vga_hs), 32'd1);
        check({tag, "_vs"},    32'(vga_vs), 32'd1);
        check({tag, "_blank"}, 32'(vga_blank), 32'd0);
        check({tag, "_rgb"},   32'({vga_r, vga_g, vga_b}), 32'h0);
        check({tag, "_rd"},    32'(grid_rd), 32'd0);
        check({tag, "_addr"},  32'(grid_addr), 32'd0);
        check({tag, "_fcnt"},  32'(frame_cnt), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 2'b00;
        reset_n   = 1'b0;
        in_hs     = 1'b1;
        in_vs     = 1'b1;
        in_blank  = 1'b0;
        CounterX  = 12'd0;
        CounterY  = 12'd0;
        game_over = 1'b0;
        #22;
        check_reset_vals("rst");

        @(posedge pixel_clk);
        #1 reset_n = 1'b1;

        // head at cell 0
        mem[0]   = 2'b10;
        in_blank = 1'b1;
        tick(1);
        check("c0_rd", 32'(grid_rd), 32'd1);
        check("c0_addr", 32'(grid_addr), 32'd0);
        tick(2);
        check("c0_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFFFF00);
        check("c0_blank", 32'(vga_blank), 32'd1);

        // last cell, body
        mem[1199] = 2'b01;
        CounterX  = 12'd639;
        CounterY  = 12'd479;
        tick(1);
        check("c1199_addr", 32'(grid_addr), 32'd1199);
        tick(2);
        check("c1199_rgb", 32'({vga_r, vga_g, vga_b}), 32'h00C000);

        // col = GRID_W-1 inside, col = GRID_W border
        CounterX = 12'd639;
        CounterY = 12'd0;
        tick(1);
        check("col39_addr", 32'(grid_addr), 32'd39);
        check("col39_rd", 32'(grid_rd), 32'd1);
        CounterX = 12'd640;
        tick(1);
        check("col40_rd", 32'(grid_rd), 32'd0);
        check("col40_addr", 32'(grid_addr), 32'd0);
        tick(2);
        check("col40_rgb", 32'({vga_r, vga_g, vga_b}), 32'h404040);

        // blanking over a food cell, blank delay
        CounterX = 12'd0;
        mem[0]   = 2'b11;
        tick(3);
        in_blank = 1'b0;
        tick(1);
        check("blk_rd", 32'(grid_rd), 32'd0);
        tick(1);
        check("blk_d2", 32'(vga_blank), 32'd1);
        tick(1);
        check("blk_d3", 32'(vga_blank), 32'd0);
        check("blk_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        in_blank = 1'b1;

        // hsync delay
        in_hs = 1'b0;
        tick(2);
        check("hs_d2", 32'(vga_hs), 32'd1);
        tick(1);
        check("hs_d3", 32'(vga_hs), 32'd0);
        in_hs = 1'b1;
        tick(3);
        check("hs_back", 32'(vga_hs), 32'd1);

        // vsync delay and first frame count
        in_vs = 1'b0;
        tick(1);
        check("fc1", 32'(frame_cnt), 32'd1);
        tick(1);
        check("vs_d2", 32'(vga_vs), 32'd1);
        tick(1);
        check("vs_d3", 32'(vga_vs), 32'd0);
        in_vs = 1'b1;
        tick(3);
        check("fc1_hold", 32'(frame_cnt), 32'd1);

        // food blink
        vs_pulse(15);
        check("fc16", 32'(frame_cnt), 32'd16);
        tick(3);
        check("food_on", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        vs_pulse(16);
        check("fc32", 32'(frame_cnt), 32'd32);
        tick(3);
        check("food_off", 32'({vga_r, vga_g, vga_b}), 32'h000000);

        // game over blink
        mem[0]    = 2'b10;
        game_over = 1'b1;
        tick(3);
        check("go_head_off", 32'({vga_r, vga_g, vga_b}), 32'hFFFF00);
        vs_pulse(16);
        check("fc48", 32'(frame_cnt), 32'd48);
        tick(3);
        check("go_head_on", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        mem[0] = 2'b01;
        tick(3);
        check("go_body_on", 32'({vga_r, vga_g, vga_b}), 32'hFF0000);
        game_over = 1'b0;
        tick(3);
        check("body_plain", 32'({vga_r, vga_g, vga_b}), 32'h00C000);
        vs_pulse(16);
        check("fc_wrap", 32'(frame_cnt), 32'd0);

        // empty cell, grid line vs interior
`ifdef SNAKE_GRID_LINES_EN
        exp_line = 24'h202020;
`else
        exp_line = 24'h000000;
`endif
        CounterX = 12'd32;
        CounterY = 12'd5;
        tick(3);
        check("x32_rgb", 32'({vga_r, vga_g, vga_b}), 32'(exp_line));
        CounterX = 12'd33;
        tick(3);
        check("x33_rgb", 32'({vga_r, vga_g, vga_b}), 32'h000000);

        // mid-line async reset
        vs_pulse(1);
        mem[0]   = 2'b10;
        CounterX = 12'd0;
        CounterY = 12'd0;
        tick(3);
        check("pre_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'hFFFF00);
        check("pre_rst_fc", 32'(frame_cnt), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge pixel_clk);
        #1 reset_n = 1'b1;
        tick(2);
        check("rel_blank", 32'(vga_blank), 32'd0);
        check("rel_rgb", 32'({vga_r, vga_g, vga_b}), 32'h0);
        tick(1);
        check("rel_rgb3", 32'({vga_r, vga_g, vga_b}), 32'hFFFF00);
        check("rel_blank3", 32'(vga_blank), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snake_pixel_renderer.md
# snake_pixel_renderer

Downstream pixel stage for the snake game VGA path. It consumes the sync, blank and pixel-coordinate outputs of the VGA timing generator and maps each visible pixel to a game-grid cell. It reads that cell's contents from a synchronous grid RAM and drives registered 24-bit RGB plus delayed sync/blank to the DE2-115 VGA DAC. Game logic owns the grid RAM write port; this block only reads.

## Interface
Parameters:
- CELL_SHIFT, 4: log2 of cell size in pixels (16×16 cells).
- GRID_W, 40: grid width in cells.
- GRID_H, 30: grid height in cells.

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- in_hs  in  1  horizontal sync from timing generator; low during sync pulse.
- in_vs  in  1  vertical sync from timing generator; low during sync pulse.
- in_blank  in  1  1 = visible pixel, 0 = blanking.
- CounterX  in  12  visible-area pixel column.
- CounterY  in  12  visible-area pixel row.
- game_over  in  1  level signal from game FSM.
- grid_rd  out  1  grid RAM read enable.
- grid_addr  out  11  grid RAM address = row*GRID_W + col.
- grid_data  in  2  RAM read data, valid 1 cycle after grid_rd. Encoding: 00 empty, 01 body, 10 head, 11 food.
- vga_r, vga_g, vga_b  out  8 each  pixel colour.
- vga_hs, vga_vs, vga_blank  out  1 each  in_hs/in_vs/in_blank delayed to align with RGB.
- frame_cnt  out  6  free-running frame counter.

## Operation
- Stage 0 (registered at edge t+1):
  - col = CounterX >> CELL_SHIFT, row = CounterY >> CELL_SHIFT (12-bit logical shift).
  - in_grid = in_blank & (col < GRID_W) & (row < GRID_H).
  - grid_rd = in_grid.
  - grid_addr = row*GRID_W + col, truncated to 11 bits; held at 0 when !in_grid.
  - Cell-edge flag, sync and blank are captured alongside.
- Stage 1 (edge t+2): RAM returns grid_data. Stage-0 side info advances one register.
- Stage 2 (edge t+3): colour select, registered onto vga_r/g/b. Priority, highest first:
  - Blanking (delayed in_blank=0): 00_00_00.
  - Visible but !in_grid (border): 40_40_40.
  - game_over=1 and frame_cnt[4]=1 and cell is body or head: FF_00_00.
  - Head: FF_FF_00.
  - Body: 00_C0_00.
  - Food: FF_00_00 if frame_cnt[4]=1, else 00_00_00.
  - Empty: 00_00_00 (see Configuration).
- Frame counter:
  - Register in_vs once, giving vs_q.
  - Increment frame_cnt on vs_q=1 & in_vs=0 (sync falling edge).
  - 6-bit wrap from 63 to 0.
  - game_over is sampled at stage 2 with no registration.

## Timing
- Fixed latency: 3 pixel_clk cycles from CounterX/CounterY/in_* to vga_*. vga_hs, vga_vs and vga_blank are in_* delayed exactly 3 cycles.
- grid_rd/grid_addr: 1 cycle after inputs. RAM must return data on the next edge; no wait states are supported.
- Reset values (asynchronous):
  - vga_hs = vga_vs = 1.
  - vga_blank = 0.
  - RGB = 0.
  - grid_rd = 0, grid_addr = 0.
  - frame_cnt = 0.
  - All pipeline registers cleared, with blank stages = 0 and sync stages = 1.
- Reset deasserted mid-line: the first 3 output cycles show blank/black. Normal output follows without any resync.
- No frame-counter increment on the first in_vs falling edge seen fewer than 1 cycle after reset (vs_q resets to 1, so one occurring at cycle 1 does count).
- Boundaries:
  - col = GRID_W−1 / row = GRID_H−1 is inside the grid.
  - col = GRID_W is border.
  - With defaults, 640×480 maps exactly to 40×30, so there is no border; border appears only with a larger visible area or a smaller grid.

## Configuration
- SNAKE_GRID_LINES_EN defined: an empty in-grid cell pixel whose CounterX or CounterY low CELL_SHIFT bits are all zero outputs 20_20_20 (grid lines). Non-empty cells are unaffected.
- Not defined: empty cells are always 00_00_00 and the edge-flag logic is removed.

## Test plan
- Reset, then CounterX=0, CounterY=0, in_blank=1, RAM cell 0 = 10 → grid_rd=1, grid_addr=0 at cycle 1; vga_r/g/b = FF/FF/00 at cycle 3.
- CounterX=639, CounterY=479, cell 1199 = 01 → grid_addr=1199; RGB=00_C0_00 three cycles later.
- in_blank=0 with RAM = 11 → grid_rd=0, RGB=0. vga_blank falls exactly 3 cycles after in_blank; vga_hs/vs edges match in_hs/in_vs delayed by 3.
- Drive 16 in_vs low pulses → frame_cnt=16; food cell then renders FF_00_00. After 16 more pulses it renders 00_00_00. After 64 pulses frame_cnt wraps to 0.
- game_over=1, frame_cnt[4]=1, head cell → FF_00_00; with frame_cnt[4]=0 → FF_FF_00.
- Assert reset_n=0 mid-line → outputs reach reset values immediately, with no clock edge. With SNAKE_GRID_LINES_EN, empty cell at CounterX=32 → 20_20_20, and at CounterX=33 → 00_00_00.
